// File: rtl/udp_pkg.sv
// rtl/udp_pkg.sv - shared types and constants for the UDP frame arbiter
// Purpose : frame width default, IPv4 ethertype, arbiter state enum, header helper.
// Ports   : none (package).
package udp_pkg;

    localparam int FRAME_WIDTH_DEF = 12000;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;

    // Byte 0 of the frame sits in the most significant bits; the ethertype
    // follows the two 6-byte MAC addresses.
    localparam int ETYPE_MSB_OFFSET = 96;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RES = 2'd2,
        RESPOND  = 2'd3
    } arb_state_t;

    function automatic logic [15:0] frame_ethertype(input logic [FRAME_WIDTH_DEF-1:0] f);
        return f[FRAME_WIDTH_DEF-1-ETYPE_MSB_OFFSET -: 16];
    endfunction

endpackage

// File: rtl/udp_rr_pick.sv
// rtl/udp_rr_pick.sv - combinational round-robin requester picker
// Purpose : return the first asserted req bit at or after ptr, wrapping.
// Ports   : req   - request vector, one bit per requester
//           ptr   - index where the search starts
//           index - chosen requester (0 when none)
//           any   - at least one request asserted
module udp_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      index,
    output logic               any
);

    logic [IW-1:0] cand;

    // Walk offsets from the far end back to ptr so the closest match is the
    // last assignment and therefore wins.
    always_comb begin
        index = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IW'((32'(ptr) + 32'(k)) % 32'(NUM_REQ));
            if (req[cand]) begin
                index = cand;
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/udp_frame_arbiter.sv
// rtl/udp_frame_arbiter.sv - round-robin arbiter sharing one frame parser port
// Purpose : grant one requester at a time, forward its frame downstream, wait
//           for the IPv4 verdict and return it, with timeout and statistics.
// Ports   : main_clk/main_rst         - clock, synchronous active-high reset
//           req_frame/req_valid/req_ready - per-requester frame handshake
//           rsp_valid/rsp_ipv4/rsp_err - per-requester result pulse
//           dn_frame/dn_valid/dn_ready/dn_ipv4 - shared parser port
//           stat_frames/stat_ipv4/stat_timeouts - saturating counters
module udp_frame_arbiter
    import udp_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int FRAME_WIDTH    = FRAME_WIDTH_DEF,
    parameter int RESULT_LAT     = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           main_clk,
    input  logic                           main_rst,
    input  logic [NUM_REQ*FRAME_WIDTH-1:0] req_frame,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [NUM_REQ-1:0]             rsp_ipv4,
    output logic [NUM_REQ-1:0]             rsp_err,
    output logic [FRAME_WIDTH-1:0]         dn_frame,
    output logic                           dn_valid,
    input  logic                           dn_ready,
    input  logic                           dn_ipv4,
    output logic [15:0]                    stat_frames,
    output logic [15:0]                    stat_ipv4,
    output logic [7:0]                     stat_timeouts
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t    state;
    logic [IW-1:0] grant;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] rr_next;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic [TW-1:0] to_cnt;
    logic [3:0]    lat_cnt;
    logic          res_ipv4;
    logic          res_err;
    logic [15:0]   frames_cnt;
    logic [15:0]   ipv4_cnt;
    logic [7:0]    tmo_cnt;
    logic          issue;
    logic          accept;
    logic          timeout;
    logic          withdraw;

    udp_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .index (pick_idx),
        .any   (pick_any)
    );

    assign issue    = (state == ISSUE);
    // A downstream handshake always wins: once dn_valid&&dn_ready has been
    // seen the parser owns the frame, even on the timeout cycle.
    assign accept   = issue && dn_ready;
    assign timeout  = issue && !dn_ready && req_valid[grant]
                      && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign withdraw = issue && !dn_ready && !req_valid[grant];
    assign rr_next  = (grant == IW'(NUM_REQ - 1)) ? '0 : grant + IW'(1);

    always_ff @(posedge main_clk) begin
        if (main_rst) begin
            state      <= IDLE;
            grant      <= '0;
            rr_ptr     <= '0;
            to_cnt     <= '0;
            lat_cnt    <= '0;
            res_ipv4   <= 1'b0;
            res_err    <= 1'b0;
            frames_cnt <= '0;
            ipv4_cnt   <= '0;
            tmo_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant  <= pick_idx;
                        to_cnt <= '0;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        lat_cnt <= '0;
                        state   <= WAIT_RES;
                    end else if (withdraw) begin
                        rr_ptr <= rr_next;
                        state  <= IDLE;
                    end else if (timeout) begin
                        res_ipv4 <= 1'b0;
                        res_err  <= 1'b1;
                        state    <= RESPOND;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                WAIT_RES: begin
                    if (lat_cnt == 4'(RESULT_LAT - 1)) begin
                        res_ipv4 <= dn_ipv4;
                        res_err  <= 1'b0;
                        state    <= RESPOND;
                    end else begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
                RESPOND: begin
                    if (frames_cnt != 16'hFFFF) frames_cnt <= frames_cnt + 16'd1;
                    if (res_ipv4 && ipv4_cnt != 16'hFFFF) ipv4_cnt <= ipv4_cnt + 16'd1;
                    if (res_err && tmo_cnt != 8'hFF) tmo_cnt <= tmo_cnt + 8'd1;
                    rr_ptr <= rr_next;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are forced low while reset is held so nothing leaks out before
    // the first reset edge has cleared the state registers.
    always_comb begin
        dn_valid  = issue && !main_rst;
        dn_frame  = '0;
        req_ready = '0;
        rsp_valid = '0;
        rsp_ipv4  = '0;
        rsp_err   = '0;
        if (dn_valid) dn_frame = req_frame[int'(grant)*FRAME_WIDTH +: FRAME_WIDTH];
        if (!main_rst) begin
            req_ready[grant] = accept || timeout;
            rsp_valid[grant] = (state == RESPOND);
            rsp_ipv4[grant]  = (state == RESPOND) && res_ipv4;
            rsp_err[grant]   = (state == RESPOND) && res_err;
        end
    end

    assign stat_frames   = main_rst ? 16'd0 : frames_cnt;
    assign stat_ipv4     = main_rst ? 16'd0 : ipv4_cnt;
    assign stat_timeouts = main_rst ? 8'd0  : tmo_cnt;

endmodule

// File: tb/tb_udp_frame_arbiter.sv
// tb/tb_udp_frame_arbiter.sv - self-checking bench for udp_frame_arbiter
module tb_udp_frame_arbiter;
    import udp_pkg::*;

    localparam int NR  = 2;
    localparam int FW  = FRAME_WIDTH_DEF;
    localparam int LAT = 1;
    localparam int TMO = 8;

    logic            main_clk = 1'b0;
    logic            main_rst = 1'b1;
    logic [NR*FW-1:0] req_frame = '0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   rsp_valid;
    logic [NR-1:0]   rsp_ipv4;
    logic [NR-1:0]   rsp_err;
    logic [FW-1:0]   dn_frame;
    logic            dn_valid;
    logic            dn_ready = 1'b0;
    logic            dn_ipv4 = 1'b0;
    logic [15:0]     stat_frames;
    logic [15:0]     stat_ipv4;
    logic [7:0]      stat_timeouts;

    udp_frame_arbiter #(
        .NUM_REQ        (NR),
        .FRAME_WIDTH    (FW),
        .RESULT_LAT     (LAT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .main_clk      (main_clk),
        .main_rst      (main_rst),
        .req_frame     (req_frame),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_ipv4      (rsp_ipv4),
        .rsp_err       (rsp_err),
        .dn_frame      (dn_frame),
        .dn_valid      (dn_valid),
        .dn_ready      (dn_ready),
        .dn_ipv4       (dn_ipv4),
        .stat_frames   (stat_frames),
        .stat_ipv4     (stat_ipv4),
        .stat_timeouts (stat_timeouts)
    );

    always #5 main_clk = ~main_clk;

    int cyc = 0;
    always @(posedge main_clk) cyc <= cyc + 1;

    typedef struct {
        int idx;
        bit ipv4;
        bit err;
    } exp_t;

    exp_t  sb[$];
    int    grant_log[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    pend[NR];
    bit    take[NR];
    int    rr_cyc = 0;
    int    m_frames = 0;
    int    m_ipv4 = 0;
    int    m_tmo = 0;
    logic  dn_ready_nxt = 1'b1;
    logic  rst_nxt = 1'b1;
    exp_t  mon_e;
    logic [NR-1:0] mon_v;
    logic [NR-1:0] mon_i;
    logic [NR-1:0] mon_r;
    int    exp_cyc;

    function automatic logic [FW-1:0] make_frame(input logic [15:0] et);
        logic [FW-1:0] f;
        f = '0;
        f[FW-1 -: 48]  = 48'hAABBCCDDEEFF;
        f[FW-49 -: 48] = 48'h112233445566;
        f[FW-97 -: 16] = et;
        f[31:0]        = $urandom;
        return f;
    endfunction

    // One clock: apply registered-style stimulus just after the rising edge,
    // then observe at the falling edge, acting as the downstream parser stub
    // and as the requesters consuming frames, and checking responses.
    task automatic tick();
        @(posedge main_clk);
        #1;
        main_rst = rst_nxt;
        dn_ready = dn_ready_nxt;
        for (int i = 0; i < NR; i++) begin
            if (take[i]) begin
                take[i] = 1'b0;
                if (pend[i] > 0) pend[i]--;
                if (pend[i] == 0) req_valid[i] = 1'b0;
            end
        end
        if (main_rst) begin
            m_frames = 0;
            m_ipv4   = 0;
            m_tmo    = 0;
        end
        @(negedge main_clk);
        if (dn_valid && dn_ready) dn_ipv4 = (frame_ethertype(dn_frame) == ETHERTYPE_IPV4);
        for (int i = 0; i < NR; i++) begin
            if (req_ready[i]) begin
                take[i] = 1'b1;
                rr_cyc  = cyc;
                grant_log.push_back(i);
            end
        end
        if (rsp_valid != '0 || rsp_ipv4 != '0 || rsp_err != '0) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rsp: valid=%b ipv4=%b err=%b, required no response",
                         rsp_valid, rsp_ipv4, rsp_err);
            end else begin
                mon_e   = sb.pop_front();
                mon_v   = NR'(1) << mon_e.idx;
                mon_i   = mon_e.ipv4 ? mon_v : '0;
                mon_r   = mon_e.err ? mon_v : '0;
                exp_cyc = rr_cyc + (mon_e.err ? 1 : 1 + LAT);
                if (rsp_valid !== mon_v || rsp_ipv4 !== mon_i || rsp_err !== mon_r || cyc != exp_cyc) begin
                    n_fail++;
                    $display("FAIL scoreboard_rsp: got valid=%b ipv4=%b err=%b cyc=%0d, required valid=%b ipv4=%b err=%b cyc=%0d",
                             rsp_valid, rsp_ipv4, rsp_err, cyc, mon_v, mon_i, mon_r, exp_cyc);
                end
                if (m_frames < 65535) m_frames++;
                if (mon_e.ipv4 && m_ipv4 < 65535) m_ipv4++;
                if (mon_e.err && m_tmo < 255) m_tmo++;
            end
        end
    endtask

    task automatic present(input int i, input logic [15:0] et, input int n,
                           input bit err, input bit push);
        req_frame[i*FW +: FW] = make_frame(et);
        req_valid[i] = 1'b1;
        pend[i] = n;
        if (push)
            for (int k = 0; k < n; k++)
                sb.push_back('{idx: i, ipv4: (et == ETHERTYPE_IPV4) && !err, err: err});
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            tick();
            if (sb.size() == 0 && req_valid == '0 && !dn_valid && rsp_valid == '0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_nxt = 1'b1;
        dn_ready_nxt = 1'b1;
        req_valid = 2'b11;
        repeat (3) tick();
        n_checks++;
        if (dn_valid !== 1'b0 || dn_frame !== '0 || req_ready !== '0) begin
            n_fail++;
            $display("FAIL reset_dn: dn_valid=%b dn_frame_hdr=%h req_ready=%b, required all 0",
                     dn_valid, dn_frame[FW-1 -: 112], req_ready);
        end
        n_checks++;
        if (rsp_valid !== '0 || rsp_ipv4 !== '0 || rsp_err !== '0) begin
            n_fail++;
            $display("FAIL reset_rsp: valid=%b ipv4=%b err=%b, required 0", rsp_valid, rsp_ipv4, rsp_err);
        end
        n_checks++;
        if (stat_frames !== 16'd0 || stat_ipv4 !== 16'd0 || stat_timeouts !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_stats: frames=%0d ipv4=%0d tmo=%0d, required 0",
                     stat_frames, stat_ipv4, stat_timeouts);
        end
        req_valid = '0;
        rst_nxt = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_ipv4_frame();
        logic [FW-1:0] f;
        bit ok;
        bit seen;
        present(0, 16'h0800, 1, 1'b0, 1'b1);
        f = req_frame[0 +: FW];
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            if (dn_valid) seen = 1'b1;
        end
        n_checks++;
        if (!seen || dn_frame !== f) begin
            n_fail++;
            $display("FAIL ipv4_dn_frame: seen=%b hdr=%h, required seen=1 hdr=%h",
                     seen, dn_frame[FW-1 -: 112], f[FW-1 -: 112]);
        end
        wait_drain(20, ok);
        tick();
        n_checks++;
        if (!ok || stat_frames !== 16'(m_frames) || stat_ipv4 !== 16'(m_ipv4) || m_frames != 1) begin
            n_fail++;
            $display("FAIL ipv4_stats: drained=%b frames=%0d ipv4=%0d, required drained=1 frames=1 ipv4=1",
                     ok, stat_frames, stat_ipv4);
        end
    endtask

    task automatic test_arp_frame();
        bit ok;
        present(1, 16'h0806, 1, 1'b0, 1'b1);
        wait_drain(20, ok);
        tick();
        n_checks++;
        if (!ok || stat_frames !== 16'(m_frames) || stat_ipv4 !== 16'(m_ipv4)) begin
            n_fail++;
            $display("FAIL arp_stats: drained=%b frames=%0d ipv4=%0d, required drained=1 frames=%0d ipv4=%0d",
                     ok, stat_frames, stat_ipv4, m_frames, m_ipv4);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        grant_log.delete();
        present(0, 16'h0800, 2, 1'b0, 1'b0);
        present(1, 16'h0806, 2, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++)
            sb.push_back('{idx: k % 2, ipv4: (k % 2) == 0, err: 1'b0});
        wait_drain(100, ok);
        tick();
        n_checks++;
        if (!ok || grant_log.size() != 4 || grant_log[0] != 0 || grant_log[1] != 1
            || grant_log[2] != 0 || grant_log[3] != 1) begin
            n_fail++;
            $display("FAIL rr_grants: drained=%b count=%0d first=%0d, required 0,1,0,1",
                     ok, grant_log.size(), grant_log.size() > 0 ? grant_log[0] : -1);
        end
        n_checks++;
        if (stat_frames !== 16'(m_frames) || stat_ipv4 !== 16'(m_ipv4)) begin
            n_fail++;
            $display("FAIL rr_stats: frames=%0d ipv4=%0d, required frames=%0d ipv4=%0d",
                     stat_frames, stat_ipv4, m_frames, m_ipv4);
        end
    endtask

    task automatic test_timeout();
        int n;
        bit got;
        bit ok;
        dn_ready_nxt = 1'b0;
        tick();
        present(0, 16'h0800, 1, 1'b1, 1'b1);
        n = 0;
        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            tick();
            if (dn_valid) n++;
            if (req_ready[0]) got = 1'b1;
        end
        n_checks++;
        if (!got || n != TMO) begin
            n_fail++;
            $display("FAIL timeout_ready: pulsed=%b issue_cycles=%0d, required pulsed=1 issue_cycles=%0d",
                     got, n, TMO);
        end
        wait_drain(20, ok);
        tick();
        n_checks++;
        if (!ok || stat_timeouts !== 8'(m_tmo) || m_tmo != 1 || stat_frames !== 16'(m_frames)) begin
            n_fail++;
            $display("FAIL timeout_stats: drained=%b tmo=%0d frames=%0d, required tmo=1 frames=%0d",
                     ok, stat_timeouts, stat_frames, m_frames);
        end
    endtask

    task automatic test_timeout_edge_accept();
        int n;
        bit got;
        bit ok;
        present(0, 16'h0800, 1, 1'b0, 1'b1);
        n = 0;
        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            tick();
            if (dn_valid) n++;
            if (req_ready[0]) got = 1'b1;
            else if (n == TMO - 1) dn_ready_nxt = 1'b1;
        end
        dn_ready_nxt = 1'b0;
        n_checks++;
        if (!got || n != TMO) begin
            n_fail++;
            $display("FAIL edge_accept_cycle: pulsed=%b issue_cycles=%0d, required pulsed=1 issue_cycles=%0d",
                     got, n, TMO);
        end
        wait_drain(20, ok);
        tick();
        n_checks++;
        if (!ok || stat_timeouts !== 8'(m_tmo) || stat_ipv4 !== 16'(m_ipv4)) begin
            n_fail++;
            $display("FAIL edge_accept_stats: drained=%b tmo=%0d ipv4=%0d, required tmo=%0d ipv4=%0d",
                     ok, stat_timeouts, stat_ipv4, m_tmo, m_ipv4);
        end
    endtask

    task automatic test_withdraw();
        int n;
        bit ok;
        logic any_ready;
        dn_ready_nxt = 1'b0;
        tick();
        present(0, 16'h0800, 1, 1'b0, 1'b0);
        n = 0;
        any_ready = 1'b0;
        for (int k = 0; k < 10 && n < 3; k++) begin
            tick();
            if (dn_valid) n++;
            if (req_ready != '0) any_ready = 1'b1;
        end
        req_valid[0] = 1'b0;
        pend[0] = 0;
        tick();
        n_checks++;
        if (n != 3 || dn_valid !== 1'b0 || any_ready || req_ready !== '0) begin
            n_fail++;
            $display("FAIL withdraw_drop: issue_cycles=%0d dn_valid=%b ready_seen=%b, required 3 0 0",
                     n, dn_valid, any_ready);
        end
        repeat (3) tick();
        n_checks++;
        if (stat_frames !== 16'(m_frames) || stat_timeouts !== 8'(m_tmo)) begin
            n_fail++;
            $display("FAIL withdraw_stats: frames=%0d tmo=%0d, required frames=%0d tmo=%0d",
                     stat_frames, stat_timeouts, m_frames, m_tmo);
        end
        dn_ready_nxt = 1'b1;
        tick();
        grant_log.delete();
        present(0, 16'h0800, 1, 1'b0, 1'b0);
        present(1, 16'h0800, 1, 1'b0, 1'b0);
        sb.push_back('{idx: 1, ipv4: 1'b1, err: 1'b0});
        sb.push_back('{idx: 0, ipv4: 1'b1, err: 1'b0});
        wait_drain(40, ok);
        tick();
        n_checks++;
        if (!ok || grant_log.size() != 2 || grant_log[0] != 1) begin
            n_fail++;
            $display("FAIL withdraw_rr_advance: drained=%b count=%0d first=%0d, required first grant 1",
                     ok, grant_log.size(), grant_log.size() > 0 ? grant_log[0] : -1);
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        bit ok;
        present(0, 16'h0800, 1, 1'b0, 1'b0);
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            tick();
            if (req_ready[0]) got = 1'b1;
        end
        rst_nxt = 1'b1;
        tick();
        rst_nxt = 1'b0;
        n_checks++;
        if (!got || dn_valid !== 1'b0 || rsp_valid !== '0 || stat_frames !== 16'd0
            || stat_ipv4 !== 16'd0 || stat_timeouts !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: accepted=%b dn_valid=%b rsp_valid=%b frames=%0d, required 1 0 0 0",
                     got, dn_valid, rsp_valid, stat_frames);
        end
        tick();
        n_checks++;
        if (rsp_valid !== '0 || dn_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_no_rsp: rsp_valid=%b dn_valid=%b, required 0 0", rsp_valid, dn_valid);
        end
        present(0, 16'h0800, 1, 1'b0, 1'b1);
        wait_drain(20, ok);
        tick();
        n_checks++;
        if (!ok || stat_frames !== 16'd1 || stat_ipv4 !== 16'd1 || m_frames != 1) begin
            n_fail++;
            $display("FAIL reset_mid_next: drained=%b frames=%0d ipv4=%0d, required drained=1 frames=1 ipv4=1",
                     ok, stat_frames, stat_ipv4);
        end
    endtask

    task automatic test_timeout_saturation();
        bit ok;
        bit all_ok;
        dn_ready_nxt = 1'b0;
        tick();
        all_ok = 1'b1;
        for (int k = 0; k < 255; k++) begin
            present(0, 16'h0800, 1, 1'b1, 1'b1);
            wait_drain(40, ok);
            if (!ok) all_ok = 1'b0;
        end
        tick();
        n_checks++;
        if (!all_ok || stat_timeouts !== 8'd255 || m_tmo != 255) begin
            n_fail++;
            $display("FAIL sat_preload: drained=%b tmo=%0d, required drained=1 tmo=255",
                     all_ok, stat_timeouts);
        end
        present(0, 16'h0800, 1, 1'b1, 1'b1);
        wait_drain(40, ok);
        tick();
        n_checks++;
        if (!ok || stat_timeouts !== 8'd255 || stat_frames !== 16'(m_frames)) begin
            n_fail++;
            $display("FAIL sat_hold: drained=%b tmo=%0d frames=%0d, required tmo=255 frames=%0d",
                     ok, stat_timeouts, stat_frames, m_frames);
        end
        dn_ready_nxt = 1'b1;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NR; i++) begin
            pend[i] = 0;
            take[i] = 1'b0;
        end
        test_reset();
        test_ipv4_frame();
        test_arp_frame();
        test_round_robin();
        test_timeout();
        test_timeout_edge_accept();
        test_withdraw();
        test_reset_mid();
        test_timeout_saturation();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_left: %0d responses outstanding, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/udp_frame_arbiter.md
UDP_FRAME_ARBITER -- requirements
Module: udp_frame_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, giving the number of requesters (legal 2..4).
REQ-002 The block SHALL have parameter FRAME_WIDTH, default 12000, giving the flat Ethernet frame width in bits.
REQ-003 The block SHALL have parameter RESULT_LAT, default 1, giving cycles from downstream acceptance to a valid dn_ipv4 (legal 1..15).
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, giving the maximum ISSUE wait before drop.
REQ-005 The block SHALL have port main_clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port main_rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port req_frame, input, NUM_REQ*FRAME_WIDTH bits: requester frames, slice i belongs to requester i.
REQ-008 The block SHALL have ports req_valid (input) and req_ready (output), NUM_REQ bits each: per-requester frame handshake.
REQ-009 The block SHALL have ports rsp_valid, rsp_ipv4 and rsp_err, outputs, NUM_REQ bits each: per-requester result.
REQ-010 The block SHALL have ports dn_frame (output, FRAME_WIDTH), dn_valid (output, 1), dn_ready (input, 1) and dn_ipv4 (input, 1): the shared parser port.
REQ-011 The block SHALL have ports stat_frames (output, 16), stat_ipv4 (output, 16) and stat_timeouts (output, 8): saturating counters.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT_RES and RESPOND.
REQ-013 IDLE: if any req_valid is high, the block SHALL register grant = first requesting index at or after rr_ptr, wrapping modulo NUM_REQ, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-014 ISSUE: dn_valid SHALL be 1 and dn_frame SHALL be req_frame slice [grant]; in all other states dn_valid SHALL be 0 and dn_frame SHALL be 0.
REQ-015 Acceptance occurs in the ISSUE cycle where dn_ready=1; in that same cycle req_ready[grant] SHALL pulse high (combinational) and the FSM SHALL go to WAIT_RES.
REQ-016 WAIT_RES: the block SHALL count RESULT_LAT cycles from acceptance, sample dn_ipv4 on the edge ending cycle T+RESULT_LAT, and go to RESPOND.
REQ-017 RESPOND (one cycle, T+RESULT_LAT+1): rsp_valid[grant]=1, rsp_ipv4[grant]=sampled value and rsp_err[grant]=0; then rr_ptr SHALL become (grant+1) mod NUM_REQ and the FSM SHALL go to IDLE.
REQ-018 Timeout: if ISSUE lasts TIMEOUT_CYCLES cycles without dn_ready, the last cycle SHALL pulse req_ready[grant] (frame consumed), and the next cycle SHALL be RESPOND with rsp_err=1 and rsp_ipv4=0.
REQ-019 A dn_ready arriving in the timeout cycle SHALL count as normal acceptance, not a timeout.
REQ-020 If req_valid[grant] falls during ISSUE, the block SHALL drop dn_valid the next cycle, return to IDLE and advance rr_ptr, with no response and no counter update.
REQ-021 req_ready, rsp_valid, rsp_ipv4 and rsp_err SHALL be zero for every non-granted requester at all times.
REQ-022 New req_valid arrivals SHALL NOT preempt the grant outside IDLE.
REQ-023 In RESPOND, stat_frames SHALL increment; stat_ipv4 SHALL increment if rsp_ipv4=1; stat_timeouts SHALL increment if rsp_err=1. All three SHALL saturate at all-ones and never wrap.
REQ-024 Best-case service SHALL be RESULT_LAT+3 cycles per frame (IDLE, ISSUE, WAIT_RES, RESPOND).

Reset
REQ-025 While main_rst=1 at a clock edge, the FSM SHALL go to IDLE, rr_ptr and grant SHALL be 0, and the timeout and latency counters SHALL be 0.
REQ-026 During reset, all outputs SHALL be 0, including dn_frame and all stat counters.
REQ-027 Reset asserted mid-transaction SHALL abandon it with no rsp_valid pulse; the requester SHALL re-present its frame.

Structure
REQ-028 The shared package udp_pkg SHALL hold the FRAME_WIDTH default, the ETHERTYPE_IPV4 = 16'h0800 constant and the arb_state_t enum.
REQ-029 The block SHALL contain one sub-module, udp_rr_pick: a combinational round-robin picker taking a req vector and ptr and returning index and any.

Verification
REQ-030 Scenario: requester 0 sends dst AA_BB_CC_DD_EE_FF / src 11_22_33_44_55_66 / ethertype 0800, with udp_main as downstream -> rsp_valid[0] and rsp_ipv4[0]=1 at acceptance+2, stat_frames=1, stat_ipv4=1.
REQ-031 Scenario: requester 1 sends ethertype 0806 -> rsp_valid[1]=1 with rsp_ipv4[1]=0, and stat_ipv4 unchanged.
REQ-032 Scenario: both requesters hold req_valid for 4 frames -> grants 0,1,0,1 with no starvation.
REQ-033 Scenario: dn_ready held 0 with TIMEOUT_CYCLES=8 -> req_ready pulses after 8 ISSUE cycles, then rsp_err=1 and stat_timeouts=1.
REQ-034 Scenario: main_rst pulsed in WAIT_RES -> no rsp_valid, all outputs 0, and the next frame is served normally.
REQ-035 Scenario: stat_timeouts preloaded via 255 timeouts, then one more -> the counter stays at 255.
